// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, FSM state type and queue entry type for the fetch unit
package fetch_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HALT  = 2'd3
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - QDEPTH-entry fetch FIFO with synchronous flush, count, head and space outputs
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int QDEPTH = 2,
    localparam int PW     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1,
    localparam int CW     = $clog2(QDEPTH + 1)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    output fetch_entry_t head_o,
    output logic         space_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t  mem_q [QDEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          pop;
    logic          push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A pop frees the slot in the same cycle, so a full queue can still take a push.
    assign pop     = pop_i && (count_q != '0);
    assign space_o = (count_q < CW'(QDEPTH)) || pop;
    assign push    = push_i && space_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - fetch PC/FSM driving word-addressed imem into a 2-entry queue toward decode
// Optional out-of-range fetch check enabled by defining FETCH_BOUNDS_CHECK_EN.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = 32'd0,
    parameter int                MEM_DEPTH = 1001,
    parameter int                QDEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ready,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt_req,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic               halted,
    output logic               fault
);

    localparam int CW = $clog2(QDEPTH + 1);

    if (MEM_DEPTH < 1) begin : g_bad_mem_depth
        $error("fetch_controller: MEM_DEPTH must be at least 1");
    end

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fpc_q, fpc_d;
    fetch_entry_t      head;
    fetch_entry_t      push_data;
    logic [CW-1:0]     q_count;
    logic              q_space;
    logic              active;
    logic              oob;
    logic              accept;
    logic              pop;

    assign active = (state_q == FETCH) || (state_q == WAIT);

`ifdef FETCH_BOUNDS_CHECK_EN
    logic fault_q;

    assign oob = active && (fpc_q > ADDR_W'(MEM_DEPTH - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            fault_q <= 1'b0;
        end else if (oob && !redirect_valid) begin
            fault_q <= 1'b1;
        end
    end

    assign fault = fault_q;
`else
    assign oob   = 1'b0;
    assign fault = 1'b0;
`endif

    assign imem_req  = active && q_space && !oob;
    assign imem_addr = fpc_q;
    assign accept    = imem_req && imem_ready;
    assign pop       = if_valid && if_ready;
    assign push_data = '{pc: fpc_q, instr: imem_rdata};
    assign if_valid  = (q_count != '0);
    assign if_instr  = head.instr;
    assign if_pc     = head.pc;
    assign halted    = (state_q == HALT);

    fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk_i       (clk),
        .rst_ni      (rst),
        .flush_i     (redirect_valid),
        .push_i      (accept && !redirect_valid),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .space_o     (q_space),
        .count_o     (q_count)
    );

    // Redirect overrides everything; a halting fetch still lands in the queue.
    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        if (redirect_valid) begin
            state_d = FETCH;
            fpc_d   = redirect_pc;
        end else begin
            if (accept) begin
                fpc_d = fpc_q + 1'b1;
            end
            if ((halt_req && active) || oob) begin
                state_d = HALT;
            end else begin
                case (state_q)
                    IDLE:    state_d = FETCH;
                    FETCH:   if (imem_req && !imem_ready) state_d = WAIT;
                    WAIT:    if (imem_ready) state_d = FETCH;
                    default: state_d = state_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            fpc_q   <= RESET_PC;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - self-checking bench for fetch_controller against a queue-level model
module tb_fetch_controller;

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        halted;
    logic        fault;

    always #5 clk = ~clk;

    fetch_controller #(.RESET_PC(32'd0), .MEM_DEPTH(1001), .QDEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_ready     (imem_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .halted         (halted),
        .fault          (fault)
    );

    // Combinational memory image: mem[a] = a + 100.
    assign imem_rdata = imem_addr + 32'd100;

    int tests = 0;
    int fails = 0;

    // Model: phase 0 = just reset, 1 = fetching, 2 = halted.
    int          m_phase;
    logic [31:0] m_fpc;
    logic        m_fault;
    logic [31:0] m_qpc[$];
    logic [31:0] m_qins[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_fpc   = 32'd0;
        m_fault = 1'b0;
        m_qpc.delete();
        m_qins.delete();
    endtask

    task automatic step(input logic r, input logic rv, input logic [31:0] rp,
                        input logic h, input logic ir, input logic mr);
        logic pop, space, oob, req;
        @(negedge clk);
        rst = r; redirect_valid = rv; redirect_pc = rp;
        halt_req = h; if_ready = ir; imem_ready = mr;
        #1;
        pop   = (m_qpc.size() > 0) && ir;
        space = (m_qpc.size() < 2) || pop;
        oob   = BOUNDS && (m_phase == 1) && (m_fpc > 32'd1000);
        req   = (m_phase == 1) && space && !oob;
        check("imem_req", imem_req, req);
        check("imem_addr", imem_addr, m_fpc);
        check("if_valid", if_valid, m_qpc.size() > 0);
        if (m_qpc.size() > 0) begin
            check("if_pc", if_pc, m_qpc[0]);
            check("if_instr", if_instr, m_qins[0]);
        end
        check("halted", halted, m_phase == 2);
        check("fault", fault, m_fault);
        if (!r) begin
            model_reset();
        end else if (rv) begin
            m_qpc.delete();
            m_qins.delete();
            m_fpc   = rp;
            m_phase = 1;
        end else begin
            if (pop) begin
                void'(m_qpc.pop_front());
                void'(m_qins.pop_front());
            end
            if (req && mr) begin
                m_qpc.push_back(m_fpc);
                m_qins.push_back(m_fpc + 32'd100);
                m_fpc = m_fpc + 32'd1;
            end
            if (oob) m_fault = 1'b1;
            if ((h && m_phase == 1) || oob) m_phase = 2;
            else if (m_phase == 0) m_phase = 1;
        end
    endtask

    task automatic reset_dut();
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        rst = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        halt_req = 1'b0; if_ready = 1'b1; imem_ready = 1'b1;
        repeat (2) @(posedge clk);
        model_reset();

        // Reset values.
        reset_dut();
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_valid", if_valid, 0);
        check("rst_instr", if_instr, 0);
        check("rst_pc", if_pc, 0);
        check("rst_halted", halted, 0);

        // Free run: one instruction per cycle, first valid after E0+1.
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        check("t1_idle_req", imem_req, 0);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        check("t1_first_req", imem_req, 1);
        check("t1_first_addr", imem_addr, 0);
        check("t1_not_valid_yet", if_valid, 0);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
            check("t1_valid", if_valid, 1);
            check("t1_pc", if_pc, k);
            check("t1_instr", if_instr, 100 + k);
        end

        // Decode stall fills the queue, then drains in order.
        reset_dut();
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
            check("t2_full_req", imem_req, 0);
            check("t2_hold_pc", if_pc, 0);
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
            check("t2_drain_pc", if_pc, k);
        end

        // Slow memory at pc 5.
        step(1'b1, 1'b1, 32'd5, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
            check("t3_wait_req", imem_req, 1);
            check("t3_wait_addr", imem_addr, 5);
            check("t3_wait_valid", if_valid, 0);
        end
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        check("t3_pc5", if_pc, 5);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        check("t3_pc6", if_pc, 6);

        // Redirect flushes queued pc 7,8.
        step(1'b1, 1'b1, 32'd7, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        check("t4_head7", if_pc, 7);
        step(1'b1, 1'b1, 32'd40, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        check("t4_flushed", if_valid, 0);
        check("t4_addr40", imem_addr, 40);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        check("t4_pc40", if_pc, 40);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        check("t4_pc41", if_pc, 41);

        // Halt at pc 12 with 10,11 queued, then redirect to 0.
        step(1'b1, 1'b1, 32'd10, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        check("t5_addr12", imem_addr, 12);
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        check("t5_halted", halted, 1);
        check("t5_no_req", imem_req, 0);
        check("t5_drain10", if_pc, 10);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        check("t5_drain11", if_pc, 11);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        check("t5_empty", if_valid, 0);
        check("t5_still_no_req", imem_req, 0);
        step(1'b1, 1'b1, 32'd0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        check("t5_unhalted", halted, 0);
        check("t5_resume_addr", imem_addr, 0);
        check("t5_resume_req", imem_req, 1);

        // Top of range: fault under bounds checking, free wrap otherwise.
        if (BOUNDS) begin
            step(1'b1, 1'b1, 32'd1001, 1'b0, 1'b1, 1'b1);
            step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
            check("t6_oob_req", imem_req, 0);
            step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
            check("t6_fault", fault, 1);
            check("t6_halted", halted, 1);
            step(1'b1, 1'b1, 32'd0, 1'b0, 1'b1, 1'b1);
            step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
            check("t6_fault_sticky", fault, 1);
            check("t6_resumed", halted, 0);
            reset_dut();
            step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
            check("t6_fault_cleared", fault, 0);
        end else begin
            step(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1);
            step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
            check("t6_top_addr", imem_addr, 32'hFFFF_FFFF);
            step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
            check("t6_wrap_addr", imem_addr, 0);
            check("t6_top_instr", if_instr, 99);
            check("t6_no_fault", fault, 0);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            logic        r, rv, h, ir, mr;
            logic [31:0] rp;
            r  = ($urandom_range(0, 199) != 0);
            rv = ($urandom_range(0, 19) == 0);
            rp = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                             : 32'($urandom_range(0, 1010));
            h  = ($urandom_range(0, 29) == 0);
            ir = ($urandom_range(0, 9) < 7);
            mr = ($urandom_range(0, 9) < 7);
            step(r, rv, rp, h, ir, mr);
        end

        // Reset after traffic must clear head storage.
        reset_dut();
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        check("end_rst_instr", if_instr, 0);
        check("end_rst_pc", if_pc, 0);
        check("end_rst_fault", fault, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
